cg_enable_ctrl: RTL

//  Enable-side controller for the clock-gating cell. It watches activity of a

---
 rtl/cg_pkg.sv | 18 +
 rtl/cg_sat_cnt.sv | 40 ++++
 rtl/cg_enable_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/cg_pkg.sv
// Shared types and default parameters for the clock-gate enable controller.
//   cg_state_t      : controller state encoding (RUN, SLEEP, WAKE)
//   CG_IDLE_W_DEF   : default idle threshold / idle counter width
//   CG_WAKE_CYC_DEF : default clock-settle cycles before wake_ack
//   CG_CNT_W_DEF    : default gated-cycle statistics counter width
package cg_pkg;

  localparam int unsigned CG_IDLE_W_DEF   = 8;
  localparam int unsigned CG_WAKE_CYC_DEF = 2;
  localparam int unsigned CG_CNT_W_DEF    = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SLEEP = 2'd1,
    WAKE  = 2'd2
  } cg_state_t;

endpackage

// File: rtl/cg_sat_cnt.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock
//   rst   : synchronous active-high reset (count -> 0)
//   clr_i : clear count to 0 (wins over inc_i)
//   inc_i : increment by one, holding at all-ones
//   cnt_o : registered count
module cg_sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear has priority; increment stops at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cg_enable_ctrl.sv
// Enable-side controller for a clock-gating cell. Watches gated-domain
// activity, produces a registered glitch-free ICG enable and runs the wake
// handshake for agents needing the domain clock.
//   clk             : always-on clock
//   rst             : synchronous active-high reset
//   busy            : gated domain has pending work
//   wake_req        : agent requests domain clock (level, held until wake_ack)
//   cfg_idle_thresh : idle edges before gating; 0 disables gating
//   cfg_force_on    : never gate; wakes the domain if gated
//   gate_en         : registered ICG enable, 1 = clock runs
//   wake_ack        : clock running and settled
//   gated           : 1 while in SLEEP
//   gated_cycles    : edges spent with gate_en=0
// Optional feature macro CG_STATS_EN builds the gated_cycles counter; without
// it the port is tied to zero.
module cg_enable_ctrl
  import cg_pkg::*;
#(
  parameter int unsigned IDLE_W   = CG_IDLE_W_DEF,
  parameter int unsigned WAKE_CYC = CG_WAKE_CYC_DEF,
  parameter int unsigned CNT_W    = CG_CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              busy,
  input  logic              wake_req,
  input  logic [IDLE_W-1:0] cfg_idle_thresh,
  input  logic              cfg_force_on,
  output logic              gate_en,
  output logic              wake_ack,
  output logic              gated,
  output logic [CNT_W-1:0]  gated_cycles
);

  localparam int unsigned WAKE_CNT_W = $clog2(WAKE_CYC + 1);
  localparam int unsigned IDLE_CMP_W = IDLE_W + 1;

  cg_state_t             state_q;
  logic                  gate_en_q;
  logic                  wake_ack_q;
  logic                  gated_q;
  logic [WAKE_CNT_W-1:0] wake_cnt_q;
  logic [IDLE_W-1:0]     idle_cnt;

  logic                  idle_c;
  logic                  in_run_c;
  logic [IDLE_CMP_W-1:0] idle_next_c;
  logic                  thresh_hit_c;

  assign idle_c   = !busy && !wake_req && !cfg_force_on;
  assign in_run_c = (state_q == RUN);

  // Count of consecutive idle samples including this edge; one extra bit so
  // a saturated counter still compares as "at or beyond" any threshold.
  assign idle_next_c  = IDLE_CMP_W'(idle_cnt) + IDLE_CMP_W'(1);
  assign thresh_hit_c = (cfg_idle_thresh != '0) &&
                        (idle_next_c >= IDLE_CMP_W'(cfg_idle_thresh));

  // Idle run length only accumulates in RUN; leaving RUN restarts it.
  cg_sat_cnt #(.W(IDLE_W)) u_idle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (!in_run_c || !idle_c),
    .inc_i (in_run_c && idle_c),
    .cnt_o (idle_cnt)
  );

  // Controller FSM; every output is a flop so gate_en only moves at posedge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      gate_en_q  <= 1'b1;
      wake_ack_q <= 1'b1;
      gated_q    <= 1'b0;
      wake_cnt_q <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (idle_c && thresh_hit_c) begin
            state_q    <= SLEEP;
            gate_en_q  <= 1'b0;
            wake_ack_q <= 1'b0;
            gated_q    <= 1'b1;
          end
        end
        SLEEP: begin
          if (!idle_c) begin
            state_q    <= WAKE;
            gate_en_q  <= 1'b1;
            gated_q    <= 1'b0;
            wake_cnt_q <= WAKE_CNT_W'(WAKE_CYC);
          end
        end
        WAKE: begin
          // Completes regardless of the request; ack lands WAKE_CYC edges
          // after gate_en rose.
          if (wake_cnt_q <= WAKE_CNT_W'(1)) begin
            state_q    <= RUN;
            wake_ack_q <= 1'b1;
            wake_cnt_q <= '0;
          end else begin
            wake_cnt_q <= wake_cnt_q - WAKE_CNT_W'(1);
          end
        end
        default: begin
          state_q    <= RUN;
          gate_en_q  <= 1'b1;
          wake_ack_q <= 1'b1;
          gated_q    <= 1'b0;
          wake_cnt_q <= '0;
        end
      endcase
    end
  end

  assign gate_en  = gate_en_q;
  assign wake_ack = wake_ack_q;
  assign gated    = gated_q;

`ifdef CG_STATS_EN
  // Counts edges on which the domain clock was held off.
  cg_sat_cnt #(.W(CNT_W)) u_gated_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (1'b0),
    .inc_i (!gate_en_q),
    .cnt_o (gated_cycles)
  );
`else
  assign gated_cycles = '0;
`endif

endmodule
